// File: rtl/alu_arbiter_seq.sv
// Round-robin arbiter that shares one combinational 64-bit ALU between two requesters,
// holding operands for a per-class multicycle window. Optional ALU_STATS_EN adds per-requester completion counters.
module alu_arbiter_seq #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_in1,
  input  logic [63:0] req0_in2,
  input  logic [2:0]  req0_funct3,
  input  logic [6:0]  req0_funct7,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_in1,
  input  logic [63:0] req1_in2,
  input  logic [2:0]  req1_funct3,
  input  logic [6:0]  req1_funct7,

  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [63:0] resp0_out,

  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [63:0] resp1_out,

  output logic [63:0] alu_in1,
  output logic [63:0] alu_in2,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  input  logic [63:0] alu_out,

  output logic        busy
`ifdef ALU_STATS_EN
  ,
  output logic [31:0] stat_cnt0,
  output logic [31:0] stat_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [6:0]       F7_MEXT   = 7'b0000001;
  localparam logic [CNT_W-1:0] MUL_HOLD  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_HOLD  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic             last_grant_q;
  logic             owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      result_q;

  logic             any_valid;
  logic             grant;
  logic             req_hs;
  logic             resp_hs;
  logic             owner_ready;
  logic [63:0]      sel_in1, sel_in2;
  logic [2:0]       sel_funct3;
  logic [6:0]       sel_funct7;

  // Cycles to hold beyond the first: zero for base (and any unrecognised) ops.
  function automatic logic [CNT_W-1:0] hold_cycles(input logic [2:0] f3, input logic [6:0] f7);
    if (f7 == F7_MEXT) return f3[2] ? DIV_HOLD : MUL_HOLD;
    return '0;
  endfunction

  // Payload of whichever requester would win this cycle.
  always_comb begin
    sel_in1    = grant ? req1_in1    : req0_in1;
    sel_in2    = grant ? req1_in2    : req0_in2;
    sel_funct3 = grant ? req1_funct3 : req0_funct3;
    sel_funct7 = grant ? req1_funct7 : req0_funct7;
  end

  // Next-state and outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    any_valid   = req0_valid | req1_valid;
    grant       = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    owner_ready = owner_q ? resp1_ready : resp0_ready;
    resp_hs     = 1'b0;

    if (rst_n && state_q == IDLE && any_valid) begin
      req0_ready = ~grant;
      req1_ready = grant;
    end
    req_hs = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    unique case (state_q)
      IDLE: if (req_hs) state_d = EXEC;
      EXEC: if (cnt_q == '0) state_d = RESP;
      RESP: begin
        resp0_valid = ~owner_q;
        resp1_valid = owner_q;
        if (owner_ready) begin
          resp_hs = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    resp0_out = result_q;
    resp1_out = result_q;
    busy      = (state_q != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every datapath register is reset, so an aborted op leaves nothing behind on alu_* or the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      result_q     <= '0;
      alu_in1      <= '0;
      alu_in2      <= '0;
      alu_funct3   <= '0;
      alu_funct7   <= '0;
    end else if (req_hs) begin
      alu_in1      <= sel_in1;
      alu_in2      <= sel_in2;
      alu_funct3   <= sel_funct3;
      alu_funct7   <= sel_funct7;
      owner_q      <= grant;
      last_grant_q <= grant;
      cnt_q        <= hold_cycles(sel_funct3, sel_funct7);
    end else if (state_q == EXEC) begin
      if (cnt_q == '0) result_q <= alu_out;
      else             cnt_q    <= cnt_q - CNT_ONE;
    end
  end

`ifdef ALU_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else if (resp_hs) begin
      if (owner_q) stat_cnt1 <= stat_cnt1 + 32'd1;
      else         stat_cnt0 <= stat_cnt0 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Scoreboard bench for alu_arbiter_seq: drivers push expected responses at request handshake,
// a negedge monitor pops and compares at each response handshake.
module tb_alu_arbiter_seq;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_DIV = 3'b100;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [2:0]  req0_funct3, req1_funct3;
  logic [6:0]  req0_funct7, req1_funct7;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [63:0] resp0_out, resp1_out;
  logic [63:0] alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic        busy;
`ifdef ALU_STATS_EN
  logic [31:0] stat_cnt0, stat_cnt1;
`endif

  always #5 clk = ~clk;

  alu_arbiter_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1), .req1_in2(req1_in2),
    .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_out(resp0_out),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_out(resp1_out),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_out(alu_out), .busy(busy)
`ifdef ALU_STATS_EN
    , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
  );

  // Stand-in combinational ALU driven by the registered alu_* outputs.
  always_comb begin
    alu_out = alu_in1 + alu_in2;
    if (alu_funct7 == F7_MEXT) begin
      if (alu_funct3[2]) alu_out = (alu_in2 == 64'd0) ? '1 : alu_in1 / alu_in2;
      else               alu_out = alu_in1 * alu_in2;
    end else if (alu_funct3 == 3'b100) begin
      alu_out = alu_in1 ^ alu_in2;
    end
  end

  typedef struct { int req; logic [63:0] val; int due; } exp_t;
  typedef struct { int req; int cyc; } grant_t;

  exp_t   sb[$];
  grant_t glog[$];
  int     cyc = 0;
  int     n_vec = 0;
  int     n_fail = 0;
  int     last_resp_cyc = 0;
  logic   prev_v[2] = '{1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp_v);
    end
  endtask

  task automatic mon_port(input int n, input logic v, input logic r, input logic [63:0] out);
    exp_t e;
    if (v && !prev_v[n]) begin
      if (sb.size() == 0) check("resp_unexpected", 64'(v), 64'd0);
      else                check("resp_latency", 64'(cyc), 64'(sb[0].due));
    end
    if (v && r && sb.size() != 0) begin
      e = sb.pop_front();
      check("resp_owner", 64'(n), 64'(e.req));
      check("resp_data", out, e.val);
      last_resp_cyc = cyc;
    end
    prev_v[n] = v;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v[0] = 1'b0;
      prev_v[1] = 1'b0;
    end else begin
      if (resp0_valid || resp1_valid) check("resp_onehot", 64'(resp0_valid & resp1_valid), 64'd0);
      mon_port(0, resp0_valid, resp0_ready, resp0_out);
      mon_port(1, resp1_valid, resp1_ready, resp1_out);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present one op, wait for its handshake, push the expectation, then drop valid.
  task automatic issue(input int n, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] exp_v, input int lat);
    bit got = 0;
    int t = 0;
    if (n == 0) begin
      req0_valid = 1'b1; req0_in1 = a; req0_in2 = b; req0_funct3 = f3; req0_funct7 = f7;
    end else begin
      req1_valid = 1'b1; req1_in1 = a; req1_in2 = b; req1_funct3 = f3; req1_funct7 = f7;
    end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if ((n == 0) ? req0_ready : req1_ready) begin
        got = 1;
        t = cyc;
      end
    end
    if (!got) check("req_ready_timeout", 64'((n == 0) ? req0_ready : req1_ready), 64'd1);
    else begin
      sb.push_back('{n, exp_v, t + lat + 1});
      glog.push_back('{n, t});
    end
    step();
    if (n == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) done = 1;
    end
    if (!done) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int gl;
    int start;
    bit seen;

    rst_n = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req1_valid = 1'b0; req1_in1 = '0; req1_in2 = '0; req1_funct3 = '0; req1_funct7 = '0;
    // A valid request during reset must not be accepted.
    req0_valid = 1'b1; req0_in1 = 64'd9; req0_in2 = 64'd9; req0_funct3 = F3_ADD; req0_funct7 = F7_BASE;
    step(); step();
    @(negedge clk);
    check("rst_req0_ready", 64'(req0_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp0_valid", 64'(resp0_valid), 64'd0);
    check("rst_resp1_valid", 64'(resp1_valid), 64'd0);
    check("rst_alu_in1", alu_in1, 64'd0);
    check("rst_alu_funct7", 64'(alu_funct7), 64'd0);
`ifdef ALU_STATS_EN
    check("rst_stat0", 64'(stat_cnt0), 64'd0);
`endif
    step();
    req0_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // 1: single ADD on req0.
    issue(0, 64'd5, 64'd7, F3_ADD, F7_BASE, 64'd12, 1);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (resp0_valid) seen = 1;
    end
    check("t1_resp0_seen", 64'(seen), 64'd1);
    check("t1_resp1_quiet", 64'(resp1_valid), 64'd0);
    wait_idle();
    step();

    // 2: MUL on req1, operands held across the whole window.
    issue(1, 64'd6, 64'd7, F3_ADD, F7_MEXT, 64'd42, MUL_LAT);
    repeat (MUL_LAT) begin
      @(negedge clk);
      check("t2_alu_in1_hold", alu_in1, 64'd6);
      check("t2_alu_in2_hold", alu_in2, 64'd7);
      check("t2_alu_f7_hold", 64'(alu_funct7), 64'(F7_MEXT));
      check("t2_busy", 64'(busy), 64'd1);
      check("t2_resp1_not_yet", 64'(resp1_valid), 64'd0);
    end
    wait_idle();
    step();

    // 3: both requesters continuously valid; grants alternate at lat+2 spacing.
    gl = glog.size();
    fork
      begin
        issue(0, 64'd1, 64'd1, F3_ADD, F7_BASE, 64'd2, 1);
        issue(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, F3_ADD, F7_BASE, 64'h8000_0000_0000_0000, 1);
      end
      begin
        issue(1, 64'd10, 64'd5, F3_ADD, F7_BASE, 64'd15, 1);
        issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, F3_ADD, F7_BASE, 64'd0, 1);
      end
    join
    if (glog.size() == gl + 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t3_grant_order", 64'(glog[gl+i].req), 64'(i % 2));
        if (i > 0) check("t3_grant_spacing", 64'(glog[gl+i].cyc - glog[gl+i-1].cyc), 64'd3);
      end
    end else begin
      check("t3_grant_count", 64'(glog.size() - gl), 64'd4);
    end
    wait_idle();
    step();

    // 4: response backpressure with req1 waiting.
    resp0_ready = 1'b0;
    issue(0, 64'd10, 64'd20, F3_ADD, F7_BASE, 64'd30, 1);
    gl = glog.size();
    fork
      issue(1, 64'd3, 64'd4, F3_ADD, F7_BASE, 64'd7, 1);
      begin
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          if (resp0_valid) seen = 1;
        end
        check("t4_resp0_seen", 64'(seen), 64'd1);
        repeat (10) begin
          @(negedge clk);
          check("t4_resp0_valid_hold", 64'(resp0_valid), 64'd1);
          check("t4_resp0_out_hold", resp0_out, 64'd30);
          check("t4_req0_ready", 64'(req0_ready), 64'd0);
          check("t4_req1_ready", 64'(req1_ready), 64'd0);
          check("t4_busy", 64'(busy), 64'd1);
        end
        step();
        resp0_ready = 1'b1;
      end
    join
    if (glog.size() > gl) check("t4_grant_after_ready", 64'(glog[gl].cyc), 64'(last_resp_cyc + 1));
    else                  check("t4_grant_count", 64'(glog.size() - gl), 64'd1);
    wait_idle();
    step();

    // 5: DIV aborted by reset in its fourth EXEC cycle.
    issue(0, 64'd100, 64'd7, F3_DIV, F7_MEXT, 64'd14, DIV_LAT);
    repeat (3) step();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_in1 = 64'd55; req0_in2 = 64'd1; req0_funct3 = F3_ADD; req0_funct7 = F7_BASE;
    @(negedge clk);
    check("t5_ready_in_reset", 64'(req0_ready), 64'd0);
    step();
    rst_n = 1'b1;
    req0_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_resp0_valid", 64'(resp0_valid), 64'd0);
    check("t5_alu_in1", alu_in1, 64'd0);
    check("t5_alu_in2", alu_in2, 64'd0);
    check("t5_alu_funct3", 64'(alu_funct3), 64'd0);
    repeat (10) @(negedge clk);
    check("t5_no_stale_resp", 64'(resp0_valid | resp1_valid), 64'd0);
    step();
    gl = glog.size();
    start = cyc;
    fork
      issue(0, 64'd1, 64'd2, F3_ADD, F7_BASE, 64'd3, 1);
      issue(1, 64'd4, 64'd4, F3_ADD, F7_BASE, 64'd8, 1);
    join
    if (glog.size() == gl + 2) begin
      check("t5_post_rst_first", 64'(glog[gl].req), 64'd0);
      check("t5_post_rst_immediate", 64'(glog[gl].cyc), 64'(start));
      check("t5_post_rst_second", 64'(glog[gl+1].req), 64'd1);
    end else begin
      check("t5_grant_count", 64'(glog.size() - gl), 64'd2);
    end
    wait_idle();
    step();

`ifdef ALU_STATS_EN
    // 6: completion counters (one op each already done since the last reset), then wrap.
    issue(0, 64'd2, 64'd2, F3_ADD, F7_BASE, 64'd4, 1);
    issue(0, 64'd3, 64'd3, F3_ADD, F7_BASE, 64'd6, 1);
    issue(1, 64'd5, 64'd5, F3_ADD, F7_BASE, 64'd10, 1);
    wait_idle();
    check("t6_stat0", 64'(stat_cnt0), 64'd3);
    check("t6_stat1", 64'(stat_cnt1), 64'd2);
    step();
    force dut.stat_cnt0 = 32'hFFFF_FFFF;
    #1;
    release dut.stat_cnt0;
    step();
    issue(0, 64'd1, 64'd1, F3_ADD, F7_BASE, 64'd2, 1);
    wait_idle();
    check("t6_stat0_wrap", 64'(stat_cnt0), 64'd0);
    step();
`endif

    check("end_sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
